// File: rtl/mem2_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
package mem2_arb_pkg;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;
endpackage

// File: rtl/mem2_arb_if.sv
// Requester-side bus of mem2_arb: two request channels plus grant/read-return.
interface mem2_arb_if
  import mem2_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);
  logic              req0, req1;
  logic              r_w0, r_w1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] d_in0, d_in1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] d_out;

  modport master (
    output req0, req1, r_w0, r_w1, addr0, addr1, d_in0, d_in1,
    input  gnt0, gnt1, rvalid0, rvalid1, d_out
  );

  modport slave (
    input  req0, req1, r_w0, r_w1, addr0, addr1, d_in0, d_in1,
    output gnt0, gnt1, rvalid0, rvalid1, d_out
  );
endinterface

// File: rtl/mem2_arb_pick.sv
// Combinational winner select: ptr chooses the winner on a tie (0 -> requester 0).
module mem2_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic any_req,
  output logic win
);
  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) win = ptr;
    else              win = req1;
  end
endmodule

// File: rtl/mem2_arb.sv
// Two-requester arbiter in front of the 32x32 mem2 memory.
// Define MEM2_ARB_RR_EN for round-robin ties; default build is fixed priority (requester 0).
module mem2_arb
  import mem2_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  mem2_arb_if.slave         bus,
  output logic              mem_r_w,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_d_in,
  input  logic [DATA_W-1:0] mem_d_out
);
  state_t            state_q, state_d;
  logic              grant;
  logic              any_req, win, ptr;
  logic              owner_q, rw_q;
  logic              gnt0_q, gnt1_q, rvalid0_q, rvalid1_q;
  logic [DATA_W-1:0] d_out_q;

`ifdef MEM2_ARB_RR_EN
  logic ptr_q;

  // Pointer moves to the loser so a held competing request wins next time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       ptr_q <= 1'b0;
    else if (grant) ptr_q <= ~win;
  end

  assign ptr = ptr_q;
`else
  assign ptr = 1'b0;
`endif

  mem2_arb_pick u_pick (
    .req0    (bus.req0),
    .req1    (bus.req1),
    .ptr     (ptr),
    .any_req (any_req),
    .win     (win)
  );

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = (rw_q == RW_WRITE) ? IDLE : RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Decoded from state so an asynchronous reset kills an in-flight write at once.
    mem_r_w = (state_q == ISSUE) && (rw_q == RW_WRITE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      rw_q      <= RW_READ;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      mem_addr  <= '0;
      mem_d_in  <= '0;
      d_out_q   <= '0;
    end else begin
      state_q   <= state_d;
      gnt0_q    <= grant & ~win;
      gnt1_q    <= grant &  win;
      rvalid0_q <= (state_q == RESP) & ~owner_q;
      rvalid1_q <= (state_q == RESP) &  owner_q;
      if (state_q == RESP) d_out_q <= mem_d_out;
      if (grant) begin
        owner_q  <= win;
        rw_q     <= win ? bus.r_w1  : bus.r_w0;
        mem_addr <= win ? bus.addr1 : bus.addr0;
        mem_d_in <= win ? bus.d_in1 : bus.d_in0;
      end
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.d_out   = d_out_q;
endmodule

// File: tb/tb_mem2_arb.sv
// Directed bench for mem2_arb with a behavioural mem2 (registered read, write on mem_r_w).
module tb_mem2_arb;
  import mem2_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_r_w;
  logic [4:0]  mem_addr;
  logic [31:0] mem_d_in, mem_d_out;
  logic [31:0] mem [32];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem2_arb_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  mem2_arb #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mem_r_w   (mem_r_w),
    .mem_addr  (mem_addr),
    .mem_d_in  (mem_d_in),
    .mem_d_out (mem_d_out)
  );

  always_ff @(posedge clk) begin
    if (mem_r_w) mem[mem_addr] <= mem_d_in;
    mem_d_out <= mem[mem_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise a request, wait one edge (grant cycle), then drop it.
  task automatic issue(input logic id, input logic rw, input logic [4:0] a, input logic [31:0] d);
    if (!id) begin
      bus.req0 = 1'b1; bus.r_w0 = rw; bus.addr0 = a; bus.d_in0 = d;
    end else begin
      bus.req1 = 1'b1; bus.r_w1 = rw; bus.addr1 = a; bus.d_in1 = d;
    end
    tick();
    if (!id) bus.req0 = 1'b0;
    else     bus.req1 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.req0 = 0; bus.req1 = 0; bus.r_w0 = 0; bus.r_w1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.d_in0 = '0; bus.d_in1 = '0;
    #12;
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, mem_r_w} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 00000", {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, mem_r_w});
    end
    checks++;
    if (mem_addr !== 5'd0 || mem_d_in !== 32'd0 || bus.d_out !== 32'd0) begin
      errors++; $display("FAIL reset_data got addr %h din %h dout %h exp 0", mem_addr, mem_d_in, bus.d_out);
    end
    @(negedge clk); rst = 1'b1;
    tick();
  endtask

  task automatic test_arbitration();
    logic exp_seq [4];
    logic got_seq [4];
    int   n = 0;
    exp_seq[0] = 1'b0;
`ifdef MEM2_ARB_RR_EN
    exp_seq[1] = 1'b1; exp_seq[2] = 1'b0; exp_seq[3] = 1'b1;
`else
    exp_seq[1] = 1'b0; exp_seq[2] = 1'b0; exp_seq[3] = 1'b0;
`endif
    bus.req0 = 1; bus.r_w0 = RW_READ; bus.addr0 = 5'd1;
    bus.req1 = 1; bus.r_w1 = RW_READ; bus.addr1 = 5'd2;
    for (int cyc = 0; cyc < 30 && n < 4; cyc++) begin
      tick();
      checks++;
      if ((bus.gnt0 && bus.gnt1) || (bus.gnt0 && bus.rvalid0) || (bus.gnt1 && bus.rvalid1)) begin
        errors++; $display("FAIL arb_exclusive cyc %0d got gnt %b%b rvalid %b%b", cyc, bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1);
      end
      if (bus.gnt0 || bus.gnt1) begin
        got_seq[n] = bus.gnt1;
        n++;
      end
    end
    bus.req0 = 0; bus.req1 = 0;
    checks++;
    if (n != 4) begin
      errors++; $display("FAIL arb_timeout got %0d grants exp 4", n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_seq[i] !== exp_seq[i]) begin
        errors++; $display("FAIL arb_order grant %0d got %b exp %b", i, got_seq[i], exp_seq[i]);
      end
    end
    repeat (3) tick();
  endtask

  task automatic test_write_read();
    issue(1'b0, RW_WRITE, 5'd5, 32'hDEADBEEF);
    checks++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0 || mem_r_w !== 1'b1 || mem_addr !== 5'd5 || mem_d_in !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_issue got gnt %b%b rw %b addr %0d din %h exp 10 1 5 deadbeef", bus.gnt0, bus.gnt1, mem_r_w, mem_addr, mem_d_in);
    end
    tick();
    checks++;
    if (mem_r_w !== 1'b0 || bus.gnt0 !== 1'b0) begin
      errors++; $display("FAIL wr_one_cycle got rw %b gnt0 %b exp 0 0", mem_r_w, bus.gnt0);
    end
    issue(1'b0, RW_READ, 5'd5, 32'd0);
    checks++;
    if (bus.gnt0 !== 1'b1 || mem_r_w !== 1'b0 || mem_addr !== 5'd5) begin
      errors++; $display("FAIL rd_issue got gnt0 %b rw %b addr %0d exp 1 0 5", bus.gnt0, mem_r_w, mem_addr);
    end
    tick();
    checks++;
    if (bus.rvalid0 !== 1'b0) begin
      errors++; $display("FAIL rd_early got rvalid0 %b exp 0", bus.rvalid0);
    end
    tick();
    checks++;
    if (bus.rvalid0 !== 1'b1 || bus.rvalid1 !== 1'b0 || bus.d_out !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_data got rvalid %b%b dout %h exp 10 deadbeef", bus.rvalid0, bus.rvalid1, bus.d_out);
    end
  endtask

  task automatic test_req_during_resp();
    issue(1'b0, RW_READ, 5'd5, 32'd0);
    tick();
    bus.req1 = 1; bus.r_w1 = RW_READ; bus.addr1 = 5'd5;
    tick();
    checks++;
    if (bus.rvalid0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
      errors++; $display("FAIL resp_wait got rvalid0 %b gnt1 %b exp 1 0", bus.rvalid0, bus.gnt1);
    end
    tick();
    checks++;
    if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0 || bus.rvalid0 !== 1'b0) begin
      errors++; $display("FAIL resp_gnt1 got gnt %b%b rvalid0 %b exp 01 0", bus.gnt0, bus.gnt1, bus.rvalid0);
    end
    bus.req1 = 0;
    repeat (2) tick();
    checks++;
    if (bus.rvalid1 !== 1'b1 || bus.rvalid0 !== 1'b0 || bus.d_out !== 32'hDEADBEEF) begin
      errors++; $display("FAIL resp_rd1 got rvalid %b%b dout %h exp 01 deadbeef", bus.rvalid0, bus.rvalid1, bus.d_out);
    end
  endtask

  task automatic test_withdraw();
    issue(1'b0, RW_WRITE, 5'd7, 32'h00000077);
    bus.req1 = 1; bus.r_w1 = RW_WRITE; bus.addr1 = 5'd8; bus.d_in1 = 32'h88;
    tick();
    bus.req1 = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.gnt1 !== 1'b0 || mem_r_w !== 1'b0) begin
        errors++; $display("FAIL withdraw cyc %0d got gnt1 %b rw %b exp 0 0", i, bus.gnt1, mem_r_w);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_access();
    issue(1'b0, RW_WRITE, 5'd3, 32'h0BADF00D);
    tick();
    issue(1'b0, RW_WRITE, 5'd3, 32'h12345678);
    checks++;
    if (mem_r_w !== 1'b1) begin
      errors++; $display("FAIL abort_pre got rw %b exp 1", mem_r_w);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, mem_r_w} !== 5'b0 || mem_addr !== 5'd0 ||
        mem_d_in !== 32'd0 || bus.d_out !== 32'd0) begin
      errors++; $display("FAIL abort_outputs got ctl %b addr %0d din %h dout %h exp all 0",
                         {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, mem_r_w}, mem_addr, mem_d_in, bus.d_out);
    end
    repeat (2) tick();
    #2 rst = 1'b1;
    tick();
    checks++;
    if (bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0) begin
      errors++; $display("FAIL abort_rvalid got %b%b exp 00", bus.rvalid0, bus.rvalid1);
    end
    issue(1'b0, RW_READ, 5'd3, 32'd0);
    repeat (2) tick();
    checks++;
    if (bus.rvalid0 !== 1'b1 || bus.d_out !== 32'h0BADF00D) begin
      errors++; $display("FAIL abort_mem got rvalid0 %b dout %h exp 1 0badf00d", bus.rvalid0, bus.d_out);
    end
  endtask

  task automatic test_boundary();
    issue(1'b0, RW_WRITE, 5'd31, 32'hAAAA5555);
    tick();
    issue(1'b1, RW_WRITE, 5'd0, 32'h0F0F0F0F);
    tick();
    issue(1'b0, RW_READ, 5'd31, 32'd0);
    checks++;
    if (bus.gnt0 !== 1'b1 || mem_addr !== 5'd31) begin
      errors++; $display("FAIL bnd_gnt0 got gnt0 %b addr %0d exp 1 31", bus.gnt0, mem_addr);
    end
    bus.req1 = 1; bus.r_w1 = RW_READ; bus.addr1 = 5'd0;
    repeat (2) tick();
    checks++;
    if (bus.rvalid0 !== 1'b1 || bus.rvalid1 !== 1'b0 || bus.d_out !== 32'hAAAA5555) begin
      errors++; $display("FAIL bnd_rd31 got rvalid %b%b dout %h exp 10 aaaa5555", bus.rvalid0, bus.rvalid1, bus.d_out);
    end
    tick();
    checks++;
    if (bus.gnt1 !== 1'b1 || mem_addr !== 5'd0 || bus.d_out !== 32'hAAAA5555) begin
      errors++; $display("FAIL bnd_gnt1 got gnt1 %b addr %0d dout %h exp 1 0 aaaa5555", bus.gnt1, mem_addr, bus.d_out);
    end
    bus.req1 = 0;
    repeat (2) tick();
    checks++;
    if (bus.rvalid1 !== 1'b1 || bus.rvalid0 !== 1'b0 || bus.d_out !== 32'h0F0F0F0F) begin
      errors++; $display("FAIL bnd_rd0 got rvalid %b%b dout %h exp 01 0f0f0f0f", bus.rvalid0, bus.rvalid1, bus.d_out);
    end
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_write_read();
    test_req_during_resp();
    test_withdraw();
    test_reset_mid_access();
    test_boundary();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
